// File: rtl/monitor_timing_rx_if.sv
// Monitor/timer bus bundle for monitor_timing_rx.
//   Timer -> monitor : MT[11:0] (MT01..MT12 one-hot), MGOJAM
//   Host  -> monitor : HALT_REQ, STEP_REQ, RUN_REQ, RSTRT_REQ (1-cycle pulses), CLR_ERR
//   Monitor outputs  : MSTP, MSTRTP (to timer), TP_NUM, MCT_CNT, GOJAM_CNT, HALTED, BUSY, ERR
// slave modport is the monitor itself; master is the host/timer side.
interface monitor_timing_rx_if #(
  parameter int unsigned CNT_W = 16
);
  logic [11:0]      MT;
  logic             MGOJAM;
  logic             HALT_REQ;
  logic             STEP_REQ;
  logic             RUN_REQ;
  logic             RSTRT_REQ;
  logic             CLR_ERR;
  logic             MSTP;
  logic             MSTRTP;
  logic [3:0]       TP_NUM;
  logic [CNT_W-1:0] MCT_CNT;
  logic [7:0]       GOJAM_CNT;
  logic             HALTED;
  logic             BUSY;
  logic [2:0]       ERR;

  modport master (
    output MT, MGOJAM, HALT_REQ, STEP_REQ, RUN_REQ, RSTRT_REQ, CLR_ERR,
    input  MSTP, MSTRTP, TP_NUM, MCT_CNT, GOJAM_CNT, HALTED, BUSY, ERR
  );

  modport slave (
    input  MT, MGOJAM, HALT_REQ, STEP_REQ, RUN_REQ, RSTRT_REQ, CLR_ERR,
    output MSTP, MSTRTP, TP_NUM, MCT_CNT, GOJAM_CNT, HALTED, BUSY, ERR
  );
endinterface

// File: rtl/monitor_timing_rx.sv
// Monitor-side receiver for the timer's MT01..MT12 timepulse lines and MGOJAM.
// Decodes the current timepulse (TP_NUM, 2 cycles after MT changes), checks
// T01->T12 sequencing, counts MCTs (T12->T01) and GOJAM rises, and runs the
// halt / single-step / restart handshake through MSTP and MSTRTP.
// Ports: SIM_CLK (sole clock), SIM_RST (sync, active-low), bus (slave modport,
// see monitor_timing_rx_if). ERR is sticky: [0] multi-hot MT, [1] out-of-order
// pulse, [2] GOJAM timeout after a restart.
module monitor_timing_rx #(
  parameter int unsigned STALL_LIMIT   = 64,
  parameter int unsigned GOJAM_TIMEOUT = 1024,
  parameter int unsigned MSTRTP_LEN    = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  monitor_timing_rx_if.slave  bus
);

  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  localparam int unsigned TMO_W   = $clog2(GOJAM_TIMEOUT + MSTRTP_LEN + 1);

  typedef enum logic [2:0] {
    ST_RUN, ST_ARMED, ST_HALTED, ST_STEP, ST_RESTART
  } state_e;

  state_e             state_q, state_d;
  logic [11:0]        mt_q, mt_d;
  logic               mgojam_q, mgojam_d;
  logic               mgojam_dly_q, mgojam_dly_d;
  logic [3:0]         tp_q, tp_d;
  logic               synced_q, synced_d;
  logic [CNT_W-1:0]   mct_q, mct_d;
  logic [7:0]         gj_q, gj_d;
  logic [2:0]         err_q, err_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [TMO_W-1:0]   rcnt_q, rcnt_d;
  logic               mstp_q, mstp_d;
  logic               mstrtp_q, mstrtp_d;

  logic [3:0] hot_cnt;
  logic [3:0] hot_idx;
  logic [3:0] tp_succ;
  logic       gojam_rise;
  logic       tp_chg;
  logic       err_multi, err_seq, err_tmo;

  // Timepulse decode operates on the registered MT copy.
  always_comb begin
    mt_d         = bus.MT;
    mgojam_d     = bus.MGOJAM;
    mgojam_dly_d = mgojam_q;
    hot_cnt      = '0;
    hot_idx      = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (mt_q[i]) begin
        hot_cnt = hot_cnt + 4'd1;
        hot_idx = 4'(i + 1);
      end
    end
    tp_succ    = (tp_q == 4'd12) ? 4'd1 : tp_q + 4'd1;
    gojam_rise = mgojam_q & ~mgojam_dly_q;
    tp_d       = tp_q;
    synced_d   = synced_q;
    mct_d      = mct_q;
    err_multi  = (hot_cnt > 4'd1);
    err_seq    = 1'b0;
    if (mgojam_q) begin
      tp_d     = '0;
      synced_d = 1'b0;
    end else if (hot_cnt == 4'd1) begin
      if (synced_q && hot_idx != tp_q && hot_idx != tp_succ) err_seq = 1'b1;
      if (synced_q && tp_q == 4'd12 && hot_idx == 4'd1) mct_d = mct_q + CNT_W'(1);
      tp_d     = hot_idx;
      synced_d = 1'b1;
    end
    gj_d   = (gojam_rise && gj_q != 8'hFF) ? gj_q + 8'd1 : gj_q;
    tp_chg = (tp_d != tp_q);
  end

  // Handshake FSM. MSTP/MSTRTP are registered and derived from the next state
  // so a reset edge clears them together with the state.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    rcnt_d  = rcnt_q;
    err_tmo = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.RSTRT_REQ) begin
          state_d = ST_RESTART;
          rcnt_d  = '0;
        end else if (bus.HALT_REQ) begin
          state_d = ST_ARMED;
          stall_d = '0;
        end
      end
      ST_ARMED: begin
        if (bus.RUN_REQ) begin
          state_d = ST_RUN;
        end else if (tp_chg) begin
          stall_d = '0;
        end else begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_d == STALL_W'(STALL_LIMIT)) state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (bus.RSTRT_REQ) begin
          state_d = ST_RESTART;
          rcnt_d  = '0;
        end else if (bus.RUN_REQ) begin
          state_d = ST_RUN;
        end else if (bus.STEP_REQ) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (bus.RUN_REQ) begin
          state_d = ST_RUN;
        end else if (tp_chg) begin
          state_d = ST_ARMED;
          stall_d = '0;
        end
      end
      ST_RESTART: begin
        if (gojam_rise) begin
          state_d = ST_RUN;
        end else if (rcnt_q == TMO_W'(GOJAM_TIMEOUT - 1)) begin
          err_tmo = 1'b1;
          state_d = ST_RUN;
        end else begin
          rcnt_d = rcnt_q + TMO_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    unique case (state_d)
      ST_ARMED, ST_HALTED: mstp_d = 1'b1;
      ST_RESTART:          mstp_d = mstp_q;
      default:             mstp_d = 1'b0;
    endcase
    mstrtp_d = (state_d == ST_RESTART) && (rcnt_d < TMO_W'(MSTRTP_LEN));

    // A fresh error in the clearing cycle survives the clear.
    err_d = (bus.CLR_ERR ? 3'b000 : err_q) | {err_tmo, err_seq, err_multi};
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      state_q      <= ST_RUN;
      mt_q         <= '0;
      mgojam_q     <= 1'b0;
      mgojam_dly_q <= 1'b0;
      tp_q         <= '0;
      synced_q     <= 1'b0;
      mct_q        <= '0;
      gj_q         <= '0;
      err_q        <= '0;
      stall_q      <= '0;
      rcnt_q       <= '0;
      mstp_q       <= 1'b0;
      mstrtp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mt_q         <= mt_d;
      mgojam_q     <= mgojam_d;
      mgojam_dly_q <= mgojam_dly_d;
      tp_q         <= tp_d;
      synced_q     <= synced_d;
      mct_q        <= mct_d;
      gj_q         <= gj_d;
      err_q        <= err_d;
      stall_q      <= stall_d;
      rcnt_q       <= rcnt_d;
      mstp_q       <= mstp_d;
      mstrtp_q     <= mstrtp_d;
    end
  end

  assign bus.MSTP      = mstp_q;
  assign bus.MSTRTP    = mstrtp_q;
  assign bus.TP_NUM    = tp_q;
  assign bus.MCT_CNT   = mct_q;
  assign bus.GOJAM_CNT = gj_q;
  assign bus.HALTED    = (state_q == ST_HALTED);
  assign bus.BUSY      = (state_q == ST_ARMED) || (state_q == ST_STEP) || (state_q == ST_RESTART);
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_monitor_timing_rx.sv
// Directed bench for monitor_timing_rx: the initial block plays both host and
// timer, stepping MT by hand and checking hand-computed outputs 1 time unit
// after each rising edge.
module tb_monitor_timing_rx;

  logic SIM_CLK;
  logic SIM_RST;
  int   n_cmp;
  int   n_bad;

  monitor_timing_rx_if #(.CNT_W(16)) bus ();

  monitor_timing_rx #(
    .STALL_LIMIT  (64),
    .GOJAM_TIMEOUT(1024),
    .MSTRTP_LEN   (4),
    .CNT_W        (16)
  ) dut (
    .SIM_CLK(SIM_CLK),
    .SIM_RST(SIM_RST),
    .bus    (bus)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge SIM_CLK);
    #1;
  endtask

  task automatic set_tp(input int n);
    if (n == 0) bus.MT = 12'h000;
    else        bus.MT = 12'h001 << (n - 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    SIM_RST       = 1'b0;
    bus.MT        = '0;
    bus.MGOJAM    = 1'b0;
    bus.HALT_REQ  = 1'b0;
    bus.STEP_REQ  = 1'b0;
    bus.RUN_REQ   = 1'b0;
    bus.RSTRT_REQ = 1'b0;
    bus.CLR_ERR   = 1'b0;
    tick(3);
    chk("rst_tp", bus.TP_NUM, 0);
    chk("rst_mstp", bus.MSTP, 0);
    chk("rst_mstrtp", bus.MSTRTP, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_mct", bus.MCT_CNT, 0);
    chk("rst_gj", bus.GOJAM_CNT, 0);
    chk("rst_halted", bus.HALTED, 0);
    chk("rst_busy", bus.BUSY, 0);
    SIM_RST = 1'b1;
    tick(1);

    // T1: full T01..T12 sweep then T01 again -> one MCT
    set_tp(1);
    tick(1);
    chk("t1_lat1", bus.TP_NUM, 0);
    tick(1);
    chk("t1_lat2", bus.TP_NUM, 1);
    tick(6);
    for (int n = 2; n <= 12; n++) begin
      set_tp(n);
      tick(8);
      chk("t1_tp", bus.TP_NUM, n);
    end
    chk("t1_mct0", bus.MCT_CNT, 0);
    set_tp(1);
    tick(8);
    chk("t1_tp1", bus.TP_NUM, 1);
    chk("t1_mct1", bus.MCT_CNT, 1);
    chk("t1_err", bus.ERR, 0);

    // T2: skip 5 -> out-of-order; multi-hot; clear, and error winning over clear
    set_tp(2); tick(8);
    set_tp(3); tick(8);
    set_tp(4); tick(8);
    chk("t2_err0", bus.ERR, 0);
    set_tp(6); tick(8);
    chk("t2_err_seq", bus.ERR, 3'b010);
    chk("t2_tp6", bus.TP_NUM, 6);
    bus.CLR_ERR = 1'b1; tick(1); bus.CLR_ERR = 1'b0;
    chk("t2_clr", bus.ERR, 0);
    bus.MT = 12'h003;
    tick(2);
    chk("t2_multi", bus.ERR, 3'b001);
    chk("t2_tp_hold", bus.TP_NUM, 6);
    bus.CLR_ERR = 1'b1; tick(1); bus.CLR_ERR = 1'b0;
    chk("t2_clr_lose", bus.ERR, 3'b001);
    bus.MT = 12'h000;
    tick(2);
    bus.CLR_ERR = 1'b1; tick(1); bus.CLR_ERR = 1'b0;
    chk("t2_clr2", bus.ERR, 0);
    chk("t2_zero_hold", bus.TP_NUM, 6);

    // T3: GOJAM desyncs; a non-successor pulse afterwards is not an error
    bus.MGOJAM = 1'b1;
    tick(2);
    chk("t3_tp0", bus.TP_NUM, 0);
    chk("t3_gj1", bus.GOJAM_CNT, 1);
    tick(2);
    chk("t3_gj_hold", bus.GOJAM_CNT, 1);
    bus.MGOJAM = 1'b0;
    tick(3);
    set_tp(9);
    tick(8);
    chk("t3_tp9", bus.TP_NUM, 9);
    chk("t3_err", bus.ERR, 0);
    chk("t3_mct", bus.MCT_CNT, 1);

    // T4: halt with stalled timer, then single step
    bus.HALT_REQ = 1'b1; tick(1); bus.HALT_REQ = 1'b0;
    chk("t4_mstp", bus.MSTP, 1);
    chk("t4_busy", bus.BUSY, 1);
    tick(63);
    chk("t4_not_halted", bus.HALTED, 0);
    tick(1);
    chk("t4_halted", bus.HALTED, 1);
    chk("t4_busy0", bus.BUSY, 0);
    bus.STEP_REQ = 1'b1; tick(1); bus.STEP_REQ = 1'b0;
    chk("t4_step_mstp", bus.MSTP, 0);
    chk("t4_step_busy", bus.BUSY, 1);
    set_tp(10);
    tick(2);
    chk("t4_step_tp", bus.TP_NUM, 10);
    chk("t4_rearm_mstp", bus.MSTP, 1);
    tick(64);
    chk("t4_rehalted", bus.HALTED, 1);
    chk("t4_err", bus.ERR, 0);

    // T6a: RUN_REQ beats HALT_REQ in HALTED
    bus.RUN_REQ = 1'b1; bus.HALT_REQ = 1'b1; tick(1);
    bus.RUN_REQ = 1'b0; bus.HALT_REQ = 1'b0;
    chk("t6_run_halted", bus.HALTED, 0);
    chk("t6_run_busy", bus.BUSY, 0);
    chk("t6_run_mstp", bus.MSTP, 0);

    // T5: restart answered by GOJAM, then restart that times out
    bus.RSTRT_REQ = 1'b1; tick(1); bus.RSTRT_REQ = 1'b0;
    chk("t5_mstrtp_on", bus.MSTRTP, 1);
    chk("t5_busy", bus.BUSY, 1);
    chk("t5_mstp", bus.MSTP, 0);
    tick(3);
    chk("t5_mstrtp_4th", bus.MSTRTP, 1);
    tick(1);
    chk("t5_mstrtp_off", bus.MSTRTP, 0);
    tick(5);
    bus.MGOJAM = 1'b1;
    tick(1);
    chk("t5_still_busy", bus.BUSY, 1);
    tick(1);
    chk("t5_done", bus.BUSY, 0);
    chk("t5_gj2", bus.GOJAM_CNT, 2);
    chk("t5_tp0", bus.TP_NUM, 0);
    chk("t5_err0", bus.ERR, 0);
    bus.MGOJAM = 1'b0;
    tick(3);
    bus.RSTRT_REQ = 1'b1; tick(1); bus.RSTRT_REQ = 1'b0;
    tick(1023);
    chk("t5_tmo_busy", bus.BUSY, 1);
    chk("t5_tmo_err0", bus.ERR, 0);
    tick(1);
    chk("t5_tmo_done", bus.BUSY, 0);
    chk("t5_tmo_err", bus.ERR, 3'b100);
    chk("t5_tmo_mstrtp", bus.MSTRTP, 0);
    bus.CLR_ERR = 1'b1; tick(1); bus.CLR_ERR = 1'b0;
    chk("t5_clr", bus.ERR, 0);

    // T6b: restart from HALTED keeps MSTP; reset mid-restart clears outputs
    bus.HALT_REQ = 1'b1; tick(1); bus.HALT_REQ = 1'b0;
    tick(64);
    chk("t6_halted", bus.HALTED, 1);
    bus.RSTRT_REQ = 1'b1; tick(1); bus.RSTRT_REQ = 1'b0;
    chk("t6_rs_mstp", bus.MSTP, 1);
    chk("t6_rs_mstrtp", bus.MSTRTP, 1);
    SIM_RST = 1'b0;
    tick(1);
    chk("t6_rst_mstrtp", bus.MSTRTP, 0);
    chk("t6_rst_mstp", bus.MSTP, 0);
    chk("t6_rst_busy", bus.BUSY, 0);
    chk("t6_rst_tp", bus.TP_NUM, 0);
    chk("t6_rst_gj", bus.GOJAM_CNT, 0);
    chk("t6_rst_mct", bus.MCT_CNT, 0);
    SIM_RST = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
